// File: rtl/pipeline_controller.sv
// Pipeline hazard controller for a five-stage in-order pipeline.
// Generates stage hold enables and bubble inserts, and sequences branch
// redirects around outstanding instruction-fetch bus transactions.
// Saturating performance counters track stalled cycles and redirects.
module pipeline_controller #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           stall_and_flush_i,
  input  logic                 if_busy_i,
  input  logic                 mem_busy_i,
  input  logic                 branch_taken_i,
  output logic [3:0]           stall_o,
  output logic [3:0]           flush_o,
  output logic                 target_latch_o,
  output logic                 pc_redirect_o,
  output logic                 redirect_pending_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] redirect_cnt_o
);

  // stall_o bit map: {pc, if_id, id_ex, ex_mem}
  localparam logic [3:0] STALL_NONE  = 4'b0000;
  localparam logic [3:0] STALL_PC    = 4'b1000;
  localparam logic [3:0] STALL_FRONT = 4'b1100;
  localparam logic [3:0] STALL_ALL   = 4'b1111;

  // flush_o bit map: {if_id, id_ex, ex_mem, mem_wb}
  localparam logic [3:0] FLUSH_NONE     = 4'b0000;
  localparam logic [3:0] FLUSH_MEM_WB   = 4'b0001;
  localparam logic [3:0] FLUSH_ID_EX    = 4'b0100;
  localparam logic [3:0] FLUSH_IF_ID    = 4'b1000;
  localparam logic [3:0] FLUSH_BRANCH   = 4'b1100;
  localparam logic [3:0] FLUSH_WAIT_MEM = 4'b1001;
  localparam logic [3:0] FLUSH_ALL      = 4'b1111;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_IF = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic load_use;
  logic unused_sf_bit0;

  // bit0 of the hazard result carries no meaning here
  assign load_use       = stall_and_flush_i[1];
  assign unused_sf_bit0 = stall_and_flush_i[0];

  // Priority-ordered hazard rules; reset overrides everything
  always_comb begin
    stall_o        = STALL_NONE;
    flush_o        = FLUSH_NONE;
    target_latch_o = 1'b0;
    pc_redirect_o  = 1'b0;
    state_nxt      = state;

    if (rst_i) begin
      flush_o   = FLUSH_ALL;
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_busy_i) begin
            // Data bus stall freezes everything; branch and load-use wait
            stall_o = STALL_ALL;
            flush_o = FLUSH_MEM_WB;
          end else if (branch_taken_i) begin
            flush_o        = FLUSH_BRANCH;
            target_latch_o = 1'b1;
            if (if_busy_i) begin
              // Fetch still in flight: hold PC and redirect once it lands
              stall_o   = STALL_PC;
              state_nxt = WAIT_IF;
            end else begin
              pc_redirect_o = 1'b1;
            end
          end else if (load_use) begin
            stall_o = STALL_FRONT;
            flush_o = FLUSH_ID_EX;
          end else if (if_busy_i) begin
            stall_o = STALL_PC;
            flush_o = FLUSH_IF_ID;
          end
        end

        WAIT_IF: begin
          // ID/EX already holds a bubble, so branch and load-use are moot
          if (mem_busy_i) begin
            stall_o = STALL_ALL;
            flush_o = FLUSH_WAIT_MEM;
          end else if (if_busy_i) begin
            stall_o = STALL_PC;
            flush_o = FLUSH_IF_ID;
          end else begin
            pc_redirect_o = 1'b1;
            flush_o       = FLUSH_IF_ID;
            state_nxt     = IDLE;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign redirect_pending_o = (state == WAIT_IF) && !rst_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturating count of cycles with any hold enable set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((stall_o != STALL_NONE) && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  // Saturating count of accepted branch redirects
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_cnt_o <= '0;
    end else if (target_latch_o && (redirect_cnt_o != '1)) begin
      redirect_cnt_o <= redirect_cnt_o + 1'b1;
    end
  end

endmodule
